// File: rtl/app_pkg.sv
// Shared types and constants for the APP result/command serial links.
package app_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned APP_RESULT_W   = 5;
    localparam int unsigned APP_CLK_DIV    = 4;
    localparam int unsigned APP_FIFO_DEPTH = 4;

    // Clock cycles for one complete frame: start + data + optional parity + stop.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned parity_en,
                                              input int unsigned clk_div);
        return (data_w + 2 + parity_en) * clk_div;
    endfunction

endpackage

// File: rtl/app_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; shared by the result and command paths.
module app_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full    = cnt[AW];
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/app_result_tx.sv
// APP result transmitter: buffers result words and serializes them as idle-high
// frames (start, data LSB first, optional even parity, stop) on a single pad.
module app_result_tx
    import app_pkg::*;
#(
    parameter int unsigned DATA_W     = APP_RESULT_W,
    parameter int unsigned FIFO_DEPTH = APP_FIFO_DEPTH,
    parameter int unsigned CLK_DIV    = APP_CLK_DIV,
    parameter int unsigned PARITY_EN  = 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic [7:0]        frame_cnt_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    tx_state_t         state_q;
    tx_state_t         state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              parity_q;
    logic              tx_q;
    logic              tx_nxt;
    logic              busy_q;
    logic              busy_nxt;
    logic [7:0]        frame_cnt_q;

    logic              push_acc;
    logic              pop;
    logic              frame_done;
    logic              bit_last;
    logic              last_data_bit;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    app_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .push    (valid_i),
        .wr_data (data_i),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign push_acc      = valid_i & ~fifo_full;
    assign bit_last      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_data_bit = (bit_cnt == BIT_W'(DATA_W - 1));

    assign ready_o     = ~fifo_full;
    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_last) state_nxt = DATA;
            end
            DATA: begin
                if (bit_last && last_data_bit) begin
                    if (PARITY_EN != 0) state_nxt = PARITY;
                    else                state_nxt = STOP;
                end
            end
            PARITY: begin
                if (bit_last) state_nxt = STOP;
            end
            STOP: begin
                if (bit_last) begin
                    frame_done = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pad and busy bits are computed from the next state so both flops lead, not lag, the FSM.
    always_comb begin
        shift_nxt = shift_q;
        tx_nxt    = 1'b1;
        if (pop) begin
            shift_nxt = fifo_rd_data;
        end else if (state_q == DATA && bit_last) begin
            shift_nxt = shift_q >> 1;
        end
        unique case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = parity_q;
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE) || push_acc ||
                   (fifo_count > {{(CW-1){1'b0}}, pop});
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            tx_q    <= tx_nxt;
            busy_q  <= busy_nxt;
            shift_q <= shift_nxt;
            if (state_q == IDLE || bit_last) div_cnt <= '0;
            else                             div_cnt <= div_cnt + 1'b1;
            if (state_q != DATA) bit_cnt <= '0;
            else if (bit_last)   bit_cnt <= bit_cnt + 1'b1;
            if (pop) parity_q <= ^fifo_rd_data;
            if (frame_done) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_app_result_tx.sv
// Directed bench for app_result_tx: reset, framing, burst/backpressure, no-parity, reset abort, counter wrap.
`timescale 1ns/1ps
module tb_app_result_tx;

    logic       clk = 1'b0;
    logic       rstb;
    logic [4:0] data_a, data_b, data_c;
    logic       valid_a, valid_b, valid_c;
    logic       ready_a, ready_b, ready_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    int         drv_idx;
    int         drv_guard;
    logic       drv_acc;
    int         dec_n;
    int         dec_guard;
    logic [4:0] dec_w;
    logic       dec_par;
    logic       dec_stop;
    int         low_cnt;
    logic [4:0] bw [5];

    always #5 clk = ~clk;

    app_result_tx #(.DATA_W(5), .FIFO_DEPTH(4), .CLK_DIV(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .rstb(rstb), .data_i(data_a), .valid_i(valid_a), .ready_o(ready_a),
        .tx_o(tx_a), .busy_o(busy_a), .frame_cnt_o(cnt_a));

    app_result_tx #(.DATA_W(5), .FIFO_DEPTH(4), .CLK_DIV(1), .PARITY_EN(0)) dut_b (
        .clk(clk), .rstb(rstb), .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b),
        .tx_o(tx_b), .busy_o(busy_b), .frame_cnt_o(cnt_b));

    app_result_tx #(.DATA_W(5), .FIFO_DEPTH(4), .CLK_DIV(1), .PARITY_EN(1)) dut_c (
        .clk(clk), .rstb(rstb), .data_i(data_c), .valid_i(valid_c), .ready_o(ready_c),
        .tx_o(tx_c), .busy_o(busy_c), .frame_cnt_o(cnt_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        repeat (3) step();
        rstb = 1'b1;
        step();
    endtask

    // Expected pad level for bit slot idx of a frame: 0 start, 1..5 data, then parity/stop.
    function automatic logic frame_bit(input logic [4:0] w, input int idx, input bit par_en);
        if (idx == 0) return 1'b0;
        if (idx <= 5) return w[idx-1];
        if (par_en && idx == 6) return ^w;
        return 1'b1;
    endfunction

    function automatic logic [4:0] wexp(input int n);
        return 5'((n * 7 + 3) % 32);
    endfunction

    initial begin
        rstb    = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        data_a  = '0;   data_b  = '0;   data_c  = '0;
        bw[0] = 5'h00; bw[1] = 5'h1F; bw[2] = 5'h01; bw[3] = 5'h10; bw[4] = 5'h0A;

        // Reset state
        repeat (3) step();
        check("rst_tx",    tx_a,    1);
        check("rst_ready", ready_a, 1);
        check("rst_busy",  busy_a,  0);
        check("rst_cnt",   cnt_a,   0);
        rstb = 1'b1;
        repeat (3) step();
        check("idle_tx",    tx_a,    1);
        check("idle_ready", ready_a, 1);
        check("idle_busy",  busy_a,  0);
        check("idle_cnt",   cnt_a,   0);

        // Single word 5'h15 at defaults
        data_a = 5'h15; valid_a = 1'b1;
        check("single_ready", ready_a, 1);
        step();
        valid_a = 1'b0;
        check("single_tx_k", tx_a, 1);
        check("single_busy_k", busy_a, 1);
        for (int j = 1; j <= 32; j++) begin
            step();
            check($sformatf("single_bit%0d", j), tx_a, frame_bit(5'h15, (j - 1) / 4, 1'b1));
        end
        step();
        check("single_end_tx",   tx_a,   1);
        check("single_end_busy", busy_a, 0);
        check("single_end_cnt",  cnt_a,  1);

        // Burst of five words, back-to-back frames
        do_reset();
        for (int j = 0; j <= 161; j++) begin
            if (j < 5) begin
                data_a = bw[j]; valid_a = 1'b1;
                check($sformatf("burst_ready_in%0d", j), ready_a, 1);
            end else begin
                valid_a = 1'b0;
            end
            step();
            if (j >= 1 && j <= 160)
                check($sformatf("burst_bit%0d", j), tx_a,
                      frame_bit(bw[(j - 1) / 32], ((j - 1) % 32) / 4, 1'b1));
            if (j == 4)   check("burst_full",        ready_a, 0);
            if (j == 32)  check("burst_full_stop0",  ready_a, 0);
            if (j == 33)  check("burst_ready_back",  ready_a, 1);
            if (j == 80)  check("burst_busy_mid",    busy_a,  1);
            if (j == 160) check("burst_cnt_last",    cnt_a,   4);
        end
        check("burst_end_tx",   tx_a,   1);
        check("burst_end_busy", busy_a, 0);
        check("burst_end_cnt",  cnt_a,  5);

        // No parity, CLK_DIV=1
        do_reset();
        data_b = 5'h03; valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            step();
            check($sformatf("nopar_bit%0d", j), tx_b, frame_bit(5'h03, j - 1, 1'b0));
        end
        step();
        check("nopar_end_tx",   tx_b,   1);
        check("nopar_end_cnt",  cnt_b,  1);
        check("nopar_end_busy", busy_b, 0);

        // Reset during the DATA state of frame 0
        do_reset();
        for (int j = 0; j < 3; j++) begin
            data_a = bw[j]; valid_a = 1'b1;
            step();
        end
        valid_a = 1'b0;
        repeat (4) step();
        check("abort_tx_low", tx_a, 0);
        #2 rstb = 1'b0;
        #1;
        check("abort_tx_async",   tx_a,    1);
        check("abort_busy_async", busy_a,  0);
        check("abort_cnt_async",  cnt_a,   0);
        check("abort_ready",      ready_a, 1);
        step();
        rstb = 1'b1;
        low_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (tx_a !== 1'b1) low_cnt++;
        end
        check("abort_no_frames", low_cnt, 0);
        check("abort_busy",      busy_a,  0);
        check("abort_cnt",       cnt_a,   0);

        // 256 frames: counter wrap and FIFO pointer wrap
        do_reset();
        fork
            begin
                drv_idx = 0;
                drv_guard = 0;
                while (drv_idx < 256 && drv_guard < 5000) begin
                    data_c  = wexp(drv_idx);
                    valid_c = 1'b1;
                    drv_acc = ready_c;
                    step();
                    drv_guard++;
                    if (drv_acc) drv_idx++;
                end
                valid_c = 1'b0;
                check("wrap_pushed", drv_idx, 256);
            end
            begin
                dec_n = 0;
                dec_guard = 0;
                while (dec_n < 256 && dec_guard < 5000) begin
                    step();
                    dec_guard++;
                    if (tx_c === 1'b0) begin
                        for (int b = 0; b < 5; b++) begin
                            step();
                            dec_w[b] = tx_c;
                        end
                        step(); dec_par  = tx_c;
                        step(); dec_stop = tx_c;
                        dec_guard += 7;
                        check($sformatf("wrap_word%0d", dec_n), dec_w, wexp(dec_n));
                        check($sformatf("wrap_par%0d", dec_n), dec_par, ^wexp(dec_n));
                        check($sformatf("wrap_stop%0d", dec_n), dec_stop, 1);
                        dec_n++;
                    end
                end
                check("wrap_frames", dec_n, 256);
            end
        join
        step();
        check("wrap_cnt",  cnt_c,  0);
        check("wrap_busy", busy_c, 0);
        check("wrap_tx",   tx_c,   1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
